// File: rtl/ctrl_stage_pipe.sv
// ctrl_stage_pipe
// Carries the 24-bit decoder control bundle through the ID/EX, EX/MEM and
// MEM/WB pipeline registers. It unpacks each stage's fields and resolves the
// write-destination register at ID. It also inserts bubbles on data hazards.
//
// Optional feature macro: CTRL_PIPE_FWD_EN
//   defined   : fwd_a/fwd_b select EX operand sources (EX/MEM before MEM/WB),
//               and only a load-use pair stalls.
//   undefined : fwd_a/fwd_b are tied to 2'b00, and any RAW against a writing
//               instruction in EX or MEM stalls. WB never stalls because the
//               register file writes before it reads.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ctrl_in[23:0]              decoder control bundle for the ID instruction
//   id_valid, id_rs/rt/rd      ID instruction valid flag and register fields
//   flush                      discard the ID instruction (taken branch/jump)
//   stall_out                  hold PC and IF/ID this cycle (combinational)
//   ex_*                       EX-stage fields
//   mem_*                      MEM-stage fields
//   wb_*                       WB-stage fields
//   fwd_a, fwd_b               EX operand source for rs/rt
//                              (10 = EX/MEM, 01 = MEM/WB, 00 = register file)

module ctrl_stage_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] ctrl_in,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        flush,
  output logic        stall_out,
  output logic        ex_valid,
  output logic [2:0]  ex_alu_op,
  output logic [1:0]  ex_s0_s2,
  output logic        ex_jal_adder,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dest,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic        mem_enable,
  output logic [1:0]  mem_size,
  output logic        mem_se,
  output logic        mem_mux,
  output logic [4:0]  mem_dest,
  output logic        mem_regwrite,
  output logic        wb_valid,
  output logic        wb_load,
  output logic        wb_memtoreg,
  output logic        wb_lo_en,
  output logic        wb_regwrite,
  output logic        wb_hi_en,
  output logic [4:0]  wb_dest,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
);

  // Only the bits a later stage still needs are carried forward.
  logic [23:0] ex_ctrl;
  logic [10:0] mem_ctrl;
  logic [4:0]  wb_ctrl;
  logic [4:0]  id_dest;
  logic        ex_regwrite;
  logic        hazard;
  logic        bubble;

  // These bits drive datapath muxes outside this block, so they are not used here.
  logic unused_ex_bits;
  assign unused_ex_bits = ^{ex_ctrl[23:22], ex_ctrl[20:16]};

  // Destination 00 resolves to r0. That suppresses regwrite everywhere downstream.
  always_comb begin
    id_dest = 5'd0;
    case (ctrl_in[19:18])
      2'b11:   id_dest = id_rd;
      2'b01:   id_dest = id_rt;
      2'b10:   id_dest = 5'd31;
      default: id_dest = 5'd0;
    endcase
  end

  assign ex_regwrite  = ex_valid  & ex_ctrl[3]  & (ex_dest  != 5'd0);
  assign mem_regwrite = mem_valid & mem_ctrl[3] & (mem_dest != 5'd0);
  assign wb_regwrite  = wb_valid  & wb_ctrl[3]  & (wb_dest  != 5'd0);

`ifdef CTRL_PIPE_FWD_EN
  assign hazard = id_valid & ex_valid & ex_ctrl[0] & ex_regwrite &
                  ((ex_dest == id_rs) | (ex_dest == id_rt));

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_dest == ex_rs))     fwd_a = 2'b10;
    else if (wb_regwrite && (wb_dest == ex_rs))  fwd_a = 2'b01;
    if (mem_regwrite && (mem_dest == ex_rt))     fwd_b = 2'b10;
    else if (wb_regwrite && (wb_dest == ex_rt))  fwd_b = 2'b01;
  end
`else
  assign hazard = id_valid &
                  ((ex_regwrite  & ((ex_dest  == id_rs) | (ex_dest  == id_rt))) |
                   (mem_regwrite & ((mem_dest == id_rs) | (mem_dest == id_rt))));
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  assign stall_out = hazard & ~flush;
  assign bubble    = flush | stall_out | ~id_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dest   <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_dest  <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_dest   <= '0;
    end else begin
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rs    <= '0;
        ex_rt    <= '0;
        ex_dest  <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= ctrl_in;
        ex_rs    <= id_rs;
        ex_rt    <= id_rt;
        ex_dest  <= id_dest;
      end
      // A bubble leaves zeros in these stages, so they can copy forward unconditionally.
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl[10:0];
      mem_dest  <= ex_dest;
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl[4:0];
      wb_dest   <= mem_dest;
    end
  end

  assign ex_alu_op    = ex_ctrl[13:11];
  assign ex_s0_s2     = ex_ctrl[15:14];
  assign ex_jal_adder = ex_ctrl[21];

  assign mem_rw     = mem_ctrl[10];
  assign mem_enable = mem_ctrl[9];
  assign mem_size   = mem_ctrl[8:7];
  assign mem_se     = mem_ctrl[6];
  assign mem_mux    = mem_ctrl[5];

  assign wb_load     = wb_ctrl[0];
  assign wb_memtoreg = wb_ctrl[1];
  assign wb_lo_en    = wb_ctrl[2];
  assign wb_hi_en    = wb_ctrl[4];

endmodule
